tile_map_writer: RTL and testbench
==================================

TILE_MAP_WRITER -- requirements
Module: tile_map_writer

Interface
REQ-001 Parameters, one per line: name, default, meaning:
- TILE_SIZE, 80, tile edge in pixels
- COLS, 8, tile columns (640/80)
- ROWS, 6, tile rows (480/80)
- FIFO_DEPTH, 4, pending update requests
REQ-002 Ports, one per line: name, direction, width, meaning:
- clk, in, 1, clock
- resetN, in, 1, asynchronous active-low reset
- StartOfFrame, in, 1, one-cycle pulse at frame start; opens the write window
- loadLevel, in, 1, one-cycle pulse; starts a full-map load from level ROM
- levelNum, in, 2, level selected for the load; sampled with loadLevel
- req_valid, in, 1, tile update request valid
- req_ready, out, 1, request accepted when valid&ready at the clock edge
- reqX, in, 11, pixel X of the tile to update
- reqY, in, 11, pixel Y of the tile to update
- req_type, in, 2, new tile type (00 = empty/clear)
- rom_addr, out, 8, level ROM address {level[1:0], row[2:0], col[2:0]}
- rom_data, in, 2, ROM tile type, valid 1 cycle after rom_addr
- wr_en, out, 1, tile array write strobe
- wr_col, out, 3, tile array column index
- wr_row, out, 3, tile array row index
- wr_type, out, 2, tile type written
- busy, out, 1, high during a level load or drain
- level_done, out, 1, one-cycle pulse when a load completes

Function
REQ-003 FSM states: IDLE, LOAD, LOAD_LAST, DRAIN.
REQ-004 IDLE->LOAD on loadLevel: latch levelNum, flush FIFO, clear the sweep index; this takes priority over every other event in every state.
REQ-005 LOAD: rom_addr = {level, row, col}; index advances col-first (col 0..7, then row+1), one address per cycle, 48 addresses total (rows 0..5).
REQ-006 Each ROM read produces wr_en=1 one cycle later, with wr_col/wr_row delayed by one cycle and wr_type=rom_data.
REQ-007 After address 47 the FSM goes to LOAD_LAST; that cycle issues the final write, then level_done pulses for 1 cycle in the next cycle and the FSM returns to IDLE.
REQ-008 req_ready = FIFO not full AND state not LOAD/LOAD_LAST.
REQ-009 An accepted request with reqX>=640 or reqY>=480 is handshaken and discarded (not enqueued).
REQ-010 Column = number of thresholds 80,160,...,560 that reqX is >= (comparator chain, no divider); row likewise for reqY up to 400; {col,row,type} is stored in the FIFO.
REQ-011 IDLE->DRAIN on StartOfFrame when FIFO non-empty: one FIFO entry is written per cycle (wr_en=1) until empty, then IDLE; updates never reach the array outside DRAIN or LOAD.
REQ-012 A simultaneous enqueue and dequeue in DRAIN is legal; the count is unchanged, and the new entry is written in the same window.
REQ-013 StartOfFrame during LOAD/LOAD_LAST is ignored; pending entries wait for the next frame.
REQ-014 FIFO full: req_ready=0; no request is ever lost or overwritten.
REQ-015 busy = state != IDLE; wr_en=0 in IDLE.
REQ-016 loadLevel during DRAIN aborts the drain; remaining entries are discarded.

Reset
REQ-017 resetN low asynchronously forces: state IDLE, FIFO empty, index 0, rom_addr 0, wr_en 0, wr_col 0, wr_row 0, wr_type 0, level_done 0, busy 0, req_ready 1 (after release).
REQ-018 Reset mid-load abandons the load; no further writes occur until a new loadLevel.

Structure
REQ-019 Package tile_pkg holds TILE_SIZE, COLS, ROWS, the tile_t 2-bit enum (EMPTY, WALL, GIFT, SPIKE) and the FSM state enum.
REQ-020 Request FIFO is sub-module tile_req_fifo (parameter DEPTH, width 8, synchronous, full/empty flags, first-word-fall-through).

Verification
REQ-021 loadLevel with levelNum=2 -> rom_addr 0x80..0xAF on consecutive cycles; 48 wr_en pulses, first write (col0,row0) 1 cycle after addr 0x80; level_done 1 cycle after the last write (col7,row5).
REQ-022 Request (X=175,Y=90,type=00) in IDLE, then StartOfFrame -> no write before the frame; then exactly 1 write: col=2,row=1,type=00.
REQ-023 5 back-to-back requests with no StartOfFrame -> 4 accepted, req_ready=0 on the 5th until the drain; StartOfFrame -> 4 writes on consecutive cycles, in order.
REQ-024 Request X=640,Y=10 -> accepted, no write at the next StartOfFrame.
REQ-025 loadLevel during DRAIN with 3 entries pending -> the drain stops and the load starts; pending entries never written.
REQ-026 resetN asserted at load address 20 -> outputs zero immediately; no wr_en after release without a new loadLevel.

Source files
------------

// File: rtl/tile_pkg.sv
// Shared types and constants for the tile-map writer: tile geometry, tile
// types, FSM states, the packed FIFO entry and the pixel-to-tile mapping.
package tile_pkg;

    localparam int TILE_SIZE = 80;
    localparam int COLS      = 8;
    localparam int ROWS      = 6;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        WALL  = 2'd1,
        GIFT  = 2'd2,
        SPIKE = 2'd3
    } tile_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        LOAD_LAST,
        DRAIN
    } state_t;

    typedef struct packed {
        logic [2:0] col;
        logic [2:0] row;
        tile_t      ttype;
    } tile_req_t;

    // Counts the tile boundaries at or below pix; a comparator chain, no divider.
    function automatic logic [2:0] tile_index(input logic [10:0] pix,
                                              input int        n_tiles,
                                              input int        tile_size);
        logic [2:0] idx;
        idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (k < n_tiles && int'({21'd0, pix}) >= k * tile_size) begin
                idx = idx + 3'd1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/tile_req_fifo.sv
// Synchronous first-word-fall-through FIFO for pending tile updates.
// A flush empties it; a push in the same cycle becomes the only entry.
module tile_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [PW-1:0]    wr_idx;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && (flush || !full);
    assign pop_ok  = pop && !empty && !flush;
    assign wr_idx  = flush ? '0 : wr_ptr_q;
    assign rd_data = mem_q[rd_ptr_q];

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = push_ok ? ptr_next('0) : '0;
            count_d  = push_ok ? CW'(1) : '0;
        end else begin
            if (push_ok) wr_ptr_d = ptr_next(wr_ptr_q);
            if (pop_ok)  rd_ptr_d = ptr_next(rd_ptr_q);
            count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_idx] <= wr_data;
    end

endmodule

// File: rtl/tile_map_writer.sv
// Writes the tile array: full-map sweeps from level ROM on loadLevel, and
// queued single-tile updates drained at the start of each frame.
module tile_map_writer
    import tile_pkg::*;
#(
    parameter int TILE_SIZE  = tile_pkg::TILE_SIZE,
    parameter int COLS       = tile_pkg::COLS,
    parameter int ROWS       = tile_pkg::ROWS,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        StartOfFrame,
    input  logic        loadLevel,
    input  logic [1:0]  levelNum,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [10:0] reqX,
    input  logic [10:0] reqY,
    input  logic [1:0]  req_type,
    output logic [7:0]  rom_addr,
    input  logic [1:0]  rom_data,
    output logic        wr_en,
    output logic [2:0]  wr_col,
    output logic [2:0]  wr_row,
    output logic [1:0]  wr_type,
    output logic        busy,
    output logic        level_done
);

    localparam int         X_LIMIT  = TILE_SIZE * COLS;
    localparam int         Y_LIMIT  = TILE_SIZE * ROWS;
    localparam logic [5:0] LAST_IDX = 6'(ROWS * COLS - 1);

    state_t     state_q, state_d;
    logic [1:0] level_q, level_d;
    logic [5:0] idx_q, idx_d;         // {row, col} sweep position
    logic       ld_vld_q, ld_vld_d;   // a ROM read was issued last cycle
    logic [5:0] ld_idx_q, ld_idx_d;
    logic       level_done_q, level_done_d;

    logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic       in_range, drain_wr;
    tile_req_t  fifo_wr, fifo_rd;

    assign in_range  = (reqX < 11'(X_LIMIT)) && (reqY < 11'(Y_LIMIT));
    assign req_ready = !fifo_full && (state_q != LOAD) && (state_q != LOAD_LAST);
    assign fifo_push = req_valid && req_ready && in_range;
    assign fifo_wr   = '{col:   tile_index(reqX, COLS, TILE_SIZE),
                         row:   tile_index(reqY, ROWS, TILE_SIZE),
                         ttype: tile_t'(req_type)};
    // A drain write is withheld in the cycle a new load aborts the drain.
    assign drain_wr  = (state_q == DRAIN) && !fifo_empty && !loadLevel;
    assign fifo_pop  = drain_wr;

    tile_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .resetN  (resetN),
        .flush   (loadLevel),
        .push    (fifo_push),
        .wr_data (fifo_wr),
        .pop     (fifo_pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_d      = state_q;
        level_d      = level_q;
        idx_d        = idx_q;
        ld_vld_d     = 1'b0;
        ld_idx_d     = idx_q;
        level_done_d = 1'b0;
        if (loadLevel) begin
            state_d = LOAD;
            level_d = levelNum;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (StartOfFrame && !fifo_empty) state_d = DRAIN;
                end
                LOAD: begin
                    ld_vld_d = 1'b1;
                    if (idx_q == LAST_IDX) state_d = LOAD_LAST;
                    else                   idx_d   = idx_q + 6'd1;
                end
                LOAD_LAST: begin
                    level_done_d = 1'b1;
                    idx_d        = '0;
                    state_d      = IDLE;
                end
                DRAIN: begin
                    if (fifo_empty) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q      <= IDLE;
            level_q      <= '0;
            idx_q        <= '0;
            ld_vld_q     <= 1'b0;
            ld_idx_q     <= '0;
            level_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            idx_q        <= idx_d;
            ld_vld_q     <= ld_vld_d;
            ld_idx_q     <= ld_idx_d;
            level_done_q <= level_done_d;
        end
    end

    always_comb begin
        rom_addr = (state_q == LOAD) ? {level_q, idx_q} : 8'd0;
        wr_en    = 1'b0;
        wr_col   = '0;
        wr_row   = '0;
        wr_type  = '0;
        if (ld_vld_q) begin
            wr_en   = 1'b1;
            wr_col  = ld_idx_q[2:0];
            wr_row  = ld_idx_q[5:3];
            wr_type = rom_data;
        end else if (drain_wr) begin
            wr_en   = 1'b1;
            wr_col  = fifo_rd.col;
            wr_row  = fifo_rd.row;
            wr_type = fifo_rd.ttype;
        end
    end

    assign busy       = (state_q != IDLE);
    assign level_done = level_done_q;

endmodule

// File: tb/tb_tile_map_writer.sv
// Directed and randomized checks of tile_map_writer against a queue-based
// model of the tile writes that the requests and level loads should cause.
module tb_tile_map_writer;

    logic        clk;
    logic        resetN;
    logic        StartOfFrame;
    logic        loadLevel;
    logic [1:0]  levelNum;
    logic        req_valid;
    logic        req_ready;
    logic [10:0] reqX;
    logic [10:0] reqY;
    logic [1:0]  req_type;
    logic [7:0]  rom_addr;
    logic [1:0]  rom_data;
    logic        wr_en;
    logic [2:0]  wr_col;
    logic [2:0]  wr_row;
    logic [1:0]  wr_type;
    logic        busy;
    logic        level_done;

    typedef struct {
        int         cyc;
        logic [7:0] e;
    } wr_rec_t;

    int         checks   = 0;
    int         failures = 0;
    int         cyc_cnt  = 0;
    logic [1:0] rom_tbl [256];
    wr_rec_t    got [$];
    logic [7:0] exp_q [$];

    tile_map_writer dut (
        .clk          (clk),
        .resetN       (resetN),
        .StartOfFrame (StartOfFrame),
        .loadLevel    (loadLevel),
        .levelNum     (levelNum),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .reqX         (reqX),
        .reqY         (reqY),
        .req_type     (req_type),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .wr_en        (wr_en),
        .wr_col       (wr_col),
        .wr_row       (wr_row),
        .wr_type      (wr_type),
        .busy         (busy),
        .level_done   (level_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc_cnt  <= cyc_cnt + 1;
        rom_data <= rom_tbl[rom_addr];
    end

    always @(negedge clk) begin
        if (resetN && wr_en) got.push_back('{cyc: cyc_cnt, e: {wr_col, wr_row, wr_type}});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Expected tile entry: tile index is plain integer division of the pixel.
    function automatic logic [7:0] model_entry(input int x, input int y, input logic [1:0] t);
        return {3'(x / 80), 3'(y / 80), t};
    endfunction

    task automatic model_load(input logic [1:0] lvl);
        for (int i = 0; i < 48; i++) begin
            exp_q.push_back({3'(i % 8), 3'(i / 8), rom_tbl[{lvl, 6'(i)}]});
        end
    endtask

    task automatic compare_writes(input string tag);
        check({tag, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s_w%0d", tag, i), {24'd0, got[i].e}, {24'd0, exp_q[i]});
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_idle"}, busy, 1'b0);
    endtask

    task automatic send_req(input int x, input int y, input logic [1:0] t, output bit acc);
        req_valid = 1'b1;
        reqX      = 11'(x);
        reqY      = 11'(y);
        req_type  = t;
        #1;
        acc = (req_ready === 1'b1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic pulse_sof();
        StartOfFrame = 1'b1;
        tick();
        StartOfFrame = 1'b0;
    endtask

    initial begin
        bit acc;
        int x, y, pend, n;
        logic [1:0] t;

        for (int i = 0; i < 256; i++) rom_tbl[i] = 2'($urandom);
        resetN       = 1'b0;
        StartOfFrame = 1'b0;
        loadLevel    = 1'b0;
        levelNum     = 2'd0;
        req_valid    = 1'b0;
        reqX         = '0;
        reqY         = '0;
        req_type     = '0;
        repeat (3) tick();

        check("rst_wr_en", wr_en, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_level_done", level_done, 1'b0);
        check("rst_rom_addr", rom_addr, 8'd0);
        check("rst_wr_fields", {wr_col, wr_row, wr_type}, 8'd0);
        resetN = 1'b1;
        tick();
        #1;
        check("rst_req_ready", req_ready, 1'b1);

        // Level 2 sweep: addresses, write timing and level_done timing.
        got.delete();
        exp_q.delete();
        levelNum  = 2'd2;
        loadLevel = 1'b1;
        tick();
        loadLevel = 1'b0;
        for (int c = 0; c < 52; c++) begin
            #1;
            if (c < 48) check($sformatf("load_addr_%0d", c), rom_addr, 8'h80 + 8'(c));
            check($sformatf("load_wr_en_%0d", c), wr_en, (c >= 1 && c <= 48));
            check($sformatf("load_busy_%0d", c), busy, (c <= 48));
            check($sformatf("load_done_%0d", c), level_done, (c == 49));
            tick();
        end
        model_load(2'd2);
        compare_writes("load2");

        // Single update held until the frame starts.
        got.delete();
        exp_q.delete();
        send_req(175, 90, 2'b00, acc);
        check("req22_acc", acc, 1'b1);
        exp_q.push_back(model_entry(175, 90, 2'b00));
        repeat (4) tick();
        check("req22_no_early_write", got.size(), 0);
        pulse_sof();
        wait_idle("req22");
        compare_writes("req22");

        // FIFO full; the fifth request waits and joins the same drain window.
        got.delete();
        exp_q.delete();
        for (int k = 0; k < 5; k++) begin
            x = $urandom_range(0, 639);
            y = $urandom_range(0, 479);
            t = 2'($urandom);
            req_valid = 1'b1;
            reqX      = 11'(x);
            reqY      = 11'(y);
            req_type  = t;
            #1;
            check($sformatf("full_ready_%0d", k), req_ready, (k < 4));
            exp_q.push_back(model_entry(x, y, t));
            if (k < 4) tick();
        end
        tick();
        #1;
        check("full_ready_held", req_ready, 1'b0);
        StartOfFrame = 1'b1;
        tick();
        StartOfFrame = 1'b0;
        n = 0;
        while (req_valid && n < 20) begin
            #1;
            acc = (req_ready === 1'b1);
            tick();
            if (acc) req_valid = 1'b0;
            n++;
        end
        check("full_fifth_accepted", req_valid, 1'b0);
        wait_idle("full");
        compare_writes("full");
        if (got.size() >= 4) begin
            for (int i = 1; i < 4; i++) begin
                check($sformatf("full_consec_%0d", i), got[i].cyc - got[0].cyc, i);
            end
        end

        // Out-of-range request is handshaken but never written.
        got.delete();
        exp_q.delete();
        send_req(640, 10, 2'b01, acc);
        check("oor_acc", acc, 1'b1);
        pulse_sof();
        #1;
        check("oor_no_drain", busy, 1'b0);
        repeat (3) tick();
        compare_writes("oor");

        // Edge pixels around tile boundaries, mixed with discarded requests.
        got.delete();
        exp_q.delete();
        send_req(79, 80, 2'b01, acc);
        exp_q.push_back(model_entry(79, 80, 2'b01));
        send_req(10, 480, 2'b10, acc);
        send_req(639, 479, 2'b11, acc);
        exp_q.push_back(model_entry(639, 479, 2'b11));
        send_req(560, 400, 2'b10, acc);
        exp_q.push_back(model_entry(560, 400, 2'b10));
        pulse_sof();
        wait_idle("edge");
        compare_writes("edge");

        // A load arriving in the first drain cycle discards all pending entries.
        got.delete();
        exp_q.delete();
        for (int k = 0; k < 3; k++) send_req($urandom_range(0, 639), $urandom_range(0, 479), 2'($urandom), acc);
        pulse_sof();
        levelNum  = 2'd1;
        loadLevel = 1'b1;
        #1;
        check("abort_no_drain_write", wr_en, 1'b0);
        tick();
        loadLevel = 1'b0;
        wait_idle("abort");
        model_load(2'd1);
        compare_writes("abort");
        got.delete();
        pulse_sof();
        #1;
        check("abort_fifo_flushed", busy, 1'b0);
        repeat (3) tick();
        check("abort_no_late_write", got.size(), 0);

        // Reset in the middle of a load.
        levelNum  = 2'd3;
        loadLevel = 1'b1;
        tick();
        loadLevel = 1'b0;
        n = 0;
        while (rom_addr !== 8'hD4 && n < 100) begin
            #1;
            if (rom_addr === 8'hD4) break;
            tick();
            n++;
        end
        check("midrst_reached_addr20", rom_addr, 8'hD4);
        #1;
        resetN = 1'b0;
        #1;
        check("midrst_wr_en", wr_en, 1'b0);
        check("midrst_rom_addr", rom_addr, 8'd0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_level_done", level_done, 1'b0);
        check("midrst_wr_fields", {wr_col, wr_row, wr_type}, 8'd0);
        tick();
        resetN = 1'b1;
        got.delete();
        repeat (60) tick();
        check("midrst_no_writes", got.size(), 0);
        check("midrst_ready", req_ready, 1'b1);

        // Randomized rounds against the queue model.
        for (int r = 0; r < 8; r++) begin
            got.delete();
            exp_q.delete();
            pend = 0;
            n = $urandom_range(1, 7);
            for (int k = 0; k < n; k++) begin
                repeat ($urandom_range(0, 2)) tick();
                x = $urandom_range(0, 719);
                y = $urandom_range(0, 519);
                t = 2'($urandom);
                send_req(x, y, t, acc);
                check($sformatf("rnd%0d_ready_%0d", r, k), acc, (pend < 4));
                if (acc && x < 640 && y < 480) begin
                    exp_q.push_back(model_entry(x, y, t));
                    pend++;
                end
            end
            pulse_sof();
            wait_idle($sformatf("rnd%0d", r));
            compare_writes($sformatf("rnd%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
